// File: rtl/tqvp_prism_pkg.sv
// Shared constants for the PRISM input conditioning block:
// register addresses, field positions and default sizes.
package tqvp_prism_pkg;

  localparam int NCH_DEF   = 7;
  localparam int PRE_W_DEF = 16;
  localparam int DB_W_DEF  = 3;

  localparam logic [5:0] ADDR_INCFG = 6'h30;
  localparam logic [5:0] ADDR_INPOL = 6'h34;
  localparam logic [5:0] ADDR_INCAP = 6'h38;
  localparam logic [5:0] ADDR_INIRQ = 6'h3C;

  localparam int CFG_PRE_LSB = 0;
  localparam int CFG_DB_LSB  = 16;
  localparam int POL_LSB     = 0;
  localparam int RISE_LSB    = 8;
  localparam int FALL_LSB    = 16;

  localparam logic [1:0] WR_32 = 2'b10;

endpackage

// File: rtl/tqvp_prism_in_cond_debounce_ch.sv
// One debounced channel: counter, filtered level, edge pulses.
// Ports: tick/clr strobes, raw level, db_len -> filt, rise, fall.
module tqvp_prism_debounce_ch
  import tqvp_prism_pkg::*;
#(
  parameter int DB_W = DB_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            clr,
  input  logic            raw,
  input  logic [DB_W-1:0] db_len,
  output logic            filt,
  output logic            rise,
  output logic            fall
);

  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      if (raw == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == db_len) begin
        filt_d = raw;
        cnt_d  = '0;
      end else begin
        cnt_d = DB_W'(cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  // Edges come from the next-state so capture lands with filt.
  assign filt = filt_q;
  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

endmodule

// File: rtl/tqvp_prism_in_cond.sv
// Input conditioning ahead of PRISM in_data: debounce, polarity,
// edge capture and irq; bus regs at 0x30-0x3C, rd_data read mux.
module tqvp_prism_in_cond
  import tqvp_prism_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int PRE_W = PRE_W_DEF,
  parameter int DB_W  = DB_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] raw_in,
  input  logic [5:0]     address,
  input  logic [31:0]    data_in,
  input  logic [1:0]     data_write_n,
  output logic [NCH-1:0] cond_out,
  output logic [31:0]    rd_data,
  output logic           irq
);

  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DB_W-1:0]  db_len_q, db_len_d;
  logic [NCH-1:0]   pol_q, pol_d;
  logic [NCH-1:0]   rise_en_q, rise_en_d;
  logic [NCH-1:0]   fall_en_q, fall_en_d;
  logic [NCH-1:0]   cap_q, cap_d;
  logic [NCH-1:0]   irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic [NCH-1:0] filt, rise, fall;
  logic [NCH-1:0] w1c, cap_set;
  logic           wr32, tick;
  logic           cfg_we, pol_we, cap_we, ien_we;
  logic           unused_data;

  assign unused_data = ^data_in[31:23];

  assign wr32   = (data_write_n == WR_32);
  assign cfg_we = wr32 && (address == ADDR_INCFG);
  assign pol_we = wr32 && (address == ADDR_INPOL);
  assign cap_we = wr32 && (address == ADDR_INCAP);
  assign ien_we = wr32 && (address == ADDR_INIRQ);

  assign tick = (pre_q == '0);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tqvp_prism_debounce_ch #(
      .DB_W(DB_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .clr    (cfg_we),
      .raw    (raw_in[g]),
      .db_len (db_len_q),
      .filt   (filt[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign cap_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c     = cap_we ? data_in[NCH-1:0] : '0;

  always_comb begin
    prescale_d = prescale_q;
    db_len_d   = db_len_q;
    pol_d      = pol_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_en_d   = irq_en_q;
    if (cfg_we) begin
      prescale_d = data_in[CFG_PRE_LSB +: PRE_W];
      db_len_d   = data_in[CFG_DB_LSB +: DB_W];
    end
    if (pol_we) begin
      pol_d     = data_in[POL_LSB +: NCH];
      rise_en_d = data_in[RISE_LSB +: NCH];
      fall_en_d = data_in[FALL_LSB +: NCH];
    end
    if (ien_we) begin
      irq_en_d = data_in[NCH-1:0];
    end
  end

  // A CFG write restarts the prescaler on the new period.
  always_comb begin
    pre_d = pre_q;
    if (cfg_we) begin
      pre_d = data_in[CFG_PRE_LSB +: PRE_W];
    end else if (tick) begin
      pre_d = prescale_q;
    end else begin
      pre_d = PRE_W'(pre_q - 1'b1);
    end
  end

  // New edges beat a simultaneous write-1-to-clear.
  assign cap_d = (cap_q & ~w1c) | cap_set;
  assign irq_d = |(cap_q & irq_en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pre_q      <= '0;
      db_len_q   <= '0;
      pol_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      cap_q      <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      db_len_q   <= db_len_d;
      pol_q      <= pol_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      cap_q      <= cap_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign cond_out = filt ^ pol_q;
  assign irq      = irq_q;

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_INCFG: begin
        rd_data[CFG_PRE_LSB +: PRE_W] = prescale_q;
        rd_data[CFG_DB_LSB +: DB_W]   = db_len_q;
      end
      ADDR_INPOL: begin
        rd_data[POL_LSB +: NCH]  = pol_q;
        rd_data[RISE_LSB +: NCH] = rise_en_q;
        rd_data[FALL_LSB +: NCH] = fall_en_q;
      end
      ADDR_INCAP: rd_data[NCH-1:0] = cap_q;
      ADDR_INIRQ: rd_data[NCH-1:0] = irq_en_q;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_prism_in_cond.sv
// Bench for tqvp_prism_in_cond: directed scenarios plus random
// traffic, checked every cycle against a streak-based model.
module tb_tqvp_prism_in_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  raw_in = '0;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [6:0]  cond_out;
  logic [31:0] rd_data;
  logic        irq;

  int total = 0;
  int bad = 0;

  tqvp_prism_in_cond dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_in       (raw_in),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .cond_out     (cond_out),
    .rd_data      (rd_data),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Model: ticks fall on a fixed period from the last CFG
  // write; a level is taken after db_len+1 disagreeing ticks.
  int         ecyc = 0;
  int         base = 0;
  logic [15:0] m_pre = '0;
  logic [2:0]  m_db = '0;
  logic [6:0]  m_pol = '0, m_rise = '0, m_fall = '0;
  logic [6:0]  m_cap = '0, m_ien = '0, m_filt = '0;
  logic        m_irq = 1'b0;
  int          m_streak [7];

  always @(posedge clk or negedge rst_n) begin : model
    logic [6:0] nf, setb, w1c;
    int         ns [7];
    bit         wr, cfgw, tick;
    if (!rst_n) begin
      ecyc <= 0; base <= 0; m_pre <= '0; m_db <= '0;
      m_pol <= '0; m_rise <= '0; m_fall <= '0;
      m_cap <= '0; m_ien <= '0; m_filt <= '0; m_irq <= 1'b0;
      for (int i = 0; i < 7; i++) m_streak[i] <= 0;
    end else begin
      wr   = (data_write_n == 2'b10);
      cfgw = wr && (address == 6'h30);
      tick = ((ecyc - base) % (int'(m_pre) + 1)) == 0;
      nf   = m_filt;
      ns   = m_streak;
      if (cfgw) begin
        for (int i = 0; i < 7; i++) ns[i] = 0;
      end else if (tick) begin
        for (int i = 0; i < 7; i++) begin
          if (raw_in[i] != m_filt[i]) begin
            ns[i] = ns[i] + 1;
            if (ns[i] > int'(m_db)) begin
              nf[i] = raw_in[i];
              ns[i] = 0;
            end
          end else begin
            ns[i] = 0;
          end
        end
      end
      setb = ((nf & ~m_filt) & m_rise) | ((~nf & m_filt) & m_fall);
      w1c  = (wr && address == 6'h38) ? data_in[6:0] : 7'h0;
      m_irq  <= |(m_cap & m_ien);
      m_cap  <= (m_cap & ~w1c) | setb;
      m_filt <= nf;
      m_streak <= ns;
      if (cfgw) begin
        m_pre <= data_in[15:0];
        m_db  <= data_in[18:16];
        base  <= ecyc + 1 + int'(data_in[15:0]);
      end
      if (wr && address == 6'h34) begin
        m_pol  <= data_in[6:0];
        m_rise <= data_in[14:8];
        m_fall <= data_in[22:16];
      end
      if (wr && address == 6'h3C) m_ien <= data_in[6:0];
      ecyc <= ecyc + 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [5:0] a);
    case (a)
      6'h30: return {13'h0, m_db, m_pre};
      6'h34: return {9'h0, m_fall, 1'b0, m_rise, 1'b0, m_pol};
      6'h38: return {25'h0, m_cap};
      6'h3C: return {25'h0, m_ien};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cond_out", 32'(cond_out), 32'(m_filt ^ m_pol));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rd_data", rd_data, exp_rd(address));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    data_write_n = 2'b10;
    step();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = rd_data;
  endtask

  logic [31:0] v;

  initial begin
    step(3);
    // reset state
    rd(6'h30, v); chk("rst cfg", v, 32'h0);
    rd(6'h34, v); chk("rst pol", v, 32'h0);
    rd(6'h38, v); chk("rst cap", v, 32'h0);
    chk("rst cond", 32'(cond_out), 32'h0);
    chk("rst irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    step(2);

    // 1: minimum latency
    wr(6'h30, 32'h0);
    step(8);
    raw_in[0] = 1'b1;
    chk("t1 before", 32'(cond_out), 32'h00);
    step();
    chk("t1 after", 32'(cond_out), 32'h01);
    chk("t1 irq", 32'(irq), 32'h0);

    // 2: prescale 3, db_len 2 -> 3 ticks of 4 cycles
    wr(6'h30, 32'h0002_0003);
    raw_in[2] = 1'b1;
    step(11);
    chk("t2 early", 32'(cond_out), 32'h01);
    step();
    chk("t2 rise", 32'(cond_out), 32'h05);
    wr(6'h30, 32'h0002_0003);
    raw_in[2] = 1'b0;
    step(4);
    raw_in[2] = 1'b1;
    step(4);
    raw_in[2] = 1'b0;
    step(11);
    chk("t2 glitch hold", 32'(cond_out), 32'h05);
    step();
    chk("t2 glitch fall", 32'(cond_out), 32'h01);

    // 3: polarity makes no edges
    wr(6'h30, 32'h0);
    raw_in = '0;
    step(2);
    wr(6'h34, 32'h007F_7F01);
    chk("t3 pol", 32'(cond_out), 32'h01);
    rd(6'h38, v); chk("t3 cap", v, 32'h0);
    wr(6'h34, 32'h007F_7F00);
    step();
    rd(6'h38, v); chk("t3 cap2", v, 32'h0);

    // 4: rise-only capture and irq
    wr(6'h34, 32'h0000_0800);
    wr(6'h3C, 32'h08);
    raw_in[3] = 1'b1;
    step();
    rd(6'h38, v); chk("t4 cap", v, 32'h08);
    chk("t4 irq0", 32'(irq), 32'h0);
    step();
    chk("t4 irq1", 32'(irq), 32'h1);
    raw_in[3] = 1'b0;
    step(2);
    rd(6'h38, v); chk("t4 nofall", v, 32'h08);
    wr(6'h38, 32'h08);
    rd(6'h38, v); chk("t4 w1c", v, 32'h0);
    step();
    chk("t4 irq off", 32'(irq), 32'h0);

    // 5: set wins over W1C
    raw_in[3] = 1'b1;
    wr(6'h38, 32'h08);
    rd(6'h38, v); chk("t5 setwins", v, 32'h08);
    wr(6'h38, 32'h08);

    // 6: async reset mid-count
    wr(6'h30, 32'h0005_0064);
    raw_in[1] = 1'b1;
    step(150);
    rst_n = 1'b0;
    #1;
    chk("t6 rst cond", 32'(cond_out), 32'h0);
    chk("t6 rst irq", 32'(irq), 32'h0);
    raw_in = '0;
    step(2);
    rst_n = 1'b1;
    step(3);
    rd(6'h38, v); chk("t6 cap", v, 32'h0);
    wr(6'h30, 32'h0);
    chk("t6 cond", 32'(cond_out), 32'h0);
    raw_in[5] = 1'b1;
    step();
    chk("t6 pass", 32'(cond_out), 32'h20);
    address = 6'h30;
    data_in = 32'h0003_0005;
    data_write_n = 2'b01;
    step();
    data_write_n = 2'b11;
    rd(6'h30, v); chk("t6 16b", v, 32'h0);

    // random traffic
    wr(6'h34, 32'h007F_7F00);
    wr(6'h3C, 32'h7F);
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 7) == 0) raw_in[b] = ~raw_in[b];
      address = 6'h30 + 6'($urandom_range(0, 4) * 4);
      data_in = $urandom;
      data_write_n = 2'b11;
      if ($urandom_range(0, 15) == 0) begin
        data_write_n = ($urandom_range(0, 3) == 0) ?
                       2'($urandom_range(0, 3)) : 2'b10;
        if (address == 6'h30)
          data_in[15:0] = 16'($urandom_range(0, 3));
      end
      step();
    end
    data_write_n = 2'b11;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
